// File: rtl/uart_mmio_peripheral_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, FSM state encodings and the STATUS word layout.
package uart_mmio_peripheral_pkg;

   localparam logic [1:0] REG_TX_DATA = 2'd0;
   localparam logic [1:0] REG_RX_DATA = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int ST_RX_OVERRUN   = 2;
   localparam int ST_TX_OVERFLOW  = 3;
   localparam int ST_RX_FRAME_ERR = 4;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   // Packed MSB-first, so tx_busy lands on bit 0 of the STATUS word.
   typedef struct packed {
      logic rx_frame_err;
      logic tx_overflow;
      logic rx_overrun;
      logic rx_valid;
      logic tx_busy;
   } status_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: two-flop synchroniser, falling-edge start detect, mid-bit
// sampling FSM. Emits a one-cycle done or frame_err pulse per frame.
module uart_rx_sampler
   import uart_mmio_peripheral_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       done,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          prev_r;
   logic [1:0]    state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    idx_r;
   logic [7:0]    shift_r;
   logic          fall_s;

   assign fall_s = prev_r & ~sync2_r;

   // Synchroniser, edge history and receive FSM; counter restarts at each sample point.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_r   <= 1'b1;
         sync2_r   <= 1'b1;
         prev_r    <= 1'b1;
         state_r   <= RX_IDLE;
         cnt_r     <= '0;
         idx_r     <= 3'd0;
         shift_r   <= 8'd0;
         rx_byte   <= 8'd0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync1_r   <= rx;
         sync2_r   <= sync1_r;
         prev_r    <= sync2_r;
         done      <= 1'b0;
         frame_err <= 1'b0;
         case (state_r)
            RX_IDLE: begin
               cnt_r <= '0;
               idx_r <= 3'd0;
               if (fall_s) begin
                  state_r <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r   <= '0;
                  state_r <= sync2_r ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            RX_DATA: begin
               if (cnt_r == LAST) begin
                  cnt_r   <= '0;
                  shift_r <= {sync2_r, shift_r[7:1]};
                  idx_r   <= idx_r + 3'd1;
                  if (idx_r == 3'd7) begin
                     state_r <= RX_STOP;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            RX_STOP: begin
               if (cnt_r == LAST) begin
                  cnt_r   <= '0;
                  state_r <= RX_IDLE;
                  if (sync2_r) begin
                     rx_byte <= shift_r;
                     done    <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: state_r <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART occupying four words: TX_DATA, RX_DATA, STATUS, CTRL.
// Reads are combinational like data RAM; writes and read side effects are clocked.
module uart_mmio_peripheral
   import uart_mmio_peripheral_pkg::*;
#(
   parameter int          LENGTH       = 32,
   parameter int unsigned BASE_WORD    = 32'h0000_0040,
   parameter int          CLKS_PER_BIT = 434
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [LENGTH-1:0] word_addr,
   input  logic              write_en,
   input  logic              read_en,
   input  logic [LENGTH-1:0] write_data,
   output logic [LENGTH-1:0] read_data,
   output logic              hit,
   input  logic              uart_rx,
   output logic              uart_tx
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]     LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [LENGTH-1:0] BASE_L  = LENGTH'(BASE_WORD);
   localparam logic [LENGTH-1:0] TOP_L   = LENGTH'(BASE_WORD + 32'd3);

   logic [1:0]    off_s;
   logic          wr_s, rd_s;
   logic          tx_wr_s, rx_rd_s, status_wr_s, ctrl_wr_s;
   logic [1:0]    tx_state_r;
   logic [CW-1:0] tx_cnt_r;
   logic [2:0]    tx_idx_r;
   logic [7:0]    tx_shift_r;
   logic          tx_line_r;
   logic          ctrl_loop_r;
   logic          rx_valid_r, rx_overrun_r, tx_overflow_r, rx_frame_err_r;
   logic [7:0]    rx_byte_r;
   logic          rx_in_s;
   logic [7:0]    smp_byte_s;
   logic          smp_done_s, smp_ferr_s;
   status_t       status_s;
   logic          unused_wdata_s;

   assign unused_wdata_s = ^write_data[LENGTH-1:8];
   assign uart_tx        = tx_line_r;
   assign rx_in_s        = ctrl_loop_r ? tx_line_r : uart_rx;

   // Window decode and qualified per-register strobes.
   always_comb begin
      hit         = (word_addr >= BASE_L) && (word_addr <= TOP_L);
      off_s       = word_addr[1:0] - BASE_L[1:0];
      wr_s        = enable & hit & write_en;
      rd_s        = enable & hit & read_en;
      tx_wr_s     = wr_s & (off_s == REG_TX_DATA);
      rx_rd_s     = rd_s & (off_s == REG_RX_DATA);
      status_wr_s = wr_s & (off_s == REG_STATUS);
      ctrl_wr_s   = wr_s & (off_s == REG_CTRL);
      status_s    = '{rx_frame_err: rx_frame_err_r, tx_overflow: tx_overflow_r,
                      rx_overrun: rx_overrun_r, rx_valid: rx_valid_r,
                      tx_busy: (tx_state_r != TX_IDLE)};
   end

   // Combinational register readback.
   always_comb begin
      read_data = {LENGTH{1'b0}};
      if (hit) begin
         case (off_s)
            REG_TX_DATA: read_data = {LENGTH{1'b0}};
            REG_RX_DATA: read_data = LENGTH'(rx_byte_r);
            REG_STATUS:  read_data = LENGTH'(status_s);
            REG_CTRL:    read_data = LENGTH'(ctrl_loop_r);
            default:     read_data = {LENGTH{1'b0}};
         endcase
      end else begin
         read_data = {LENGTH{1'b0}};
      end
   end

   // TX serialiser: start bit driven on the accepting edge, then 8 data bits and stop.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= '0;
         tx_idx_r   <= 3'd0;
         tx_shift_r <= 8'd0;
         tx_line_r  <= 1'b1;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               tx_cnt_r <= '0;
               tx_idx_r <= 3'd0;
               if (tx_wr_s) begin
                  tx_shift_r <= write_data[7:0];
                  tx_line_r  <= 1'b0;
                  tx_state_r <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_r == LAST) begin
                  tx_cnt_r   <= '0;
                  tx_line_r  <= tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                  tx_state_r <= TX_DATA;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CW'(1);
               end
            end
            TX_DATA: begin
               if (tx_cnt_r == LAST) begin
                  tx_cnt_r <= '0;
                  if (tx_idx_r == 3'd7) begin
                     tx_line_r  <= 1'b1;
                     tx_state_r <= TX_STOP;
                  end else begin
                     tx_idx_r   <= tx_idx_r + 3'd1;
                     tx_line_r  <= tx_shift_r[0];
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + CW'(1);
               end
            end
            TX_STOP: begin
               if (tx_cnt_r == LAST) begin
                  tx_cnt_r   <= '0;
                  tx_state_r <= TX_IDLE;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CW'(1);
               end
            end
            default: begin
               tx_state_r <= TX_IDLE;
               tx_line_r  <= 1'b1;
            end
         endcase
      end
   end

   // Control, received byte and sticky flags; a set in the same cycle as a clear wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl_loop_r    <= 1'b0;
         rx_byte_r      <= 8'd0;
         rx_valid_r     <= 1'b0;
         rx_overrun_r   <= 1'b0;
         tx_overflow_r  <= 1'b0;
         rx_frame_err_r <= 1'b0;
      end else begin
         if (ctrl_wr_s) begin
            ctrl_loop_r <= write_data[0];
         end
         if (smp_done_s && (!rx_valid_r || rx_rd_s)) begin
            rx_byte_r  <= smp_byte_s;
            rx_valid_r <= 1'b1;
         end else if (rx_rd_s) begin
            rx_valid_r <= 1'b0;
         end
         rx_overrun_r   <= (smp_done_s & rx_valid_r & ~rx_rd_s) |
                           (rx_overrun_r & ~(status_wr_s & write_data[ST_RX_OVERRUN]));
         tx_overflow_r  <= (tx_wr_s & (tx_state_r != TX_IDLE)) |
                           (tx_overflow_r & ~(status_wr_s & write_data[ST_TX_OVERFLOW]));
         rx_frame_err_r <= smp_ferr_s |
                           (rx_frame_err_r & ~(status_wr_s & write_data[ST_RX_FRAME_ERR]));
      end
   end

   uart_rx_sampler #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clock     (clock),
      .reset     (reset),
      .rx        (rx_in_s),
      .rx_byte   (smp_byte_s),
      .done      (smp_done_s),
      .frame_err (smp_ferr_s)
   );

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Directed bench for uart_mmio_peripheral at 4 clocks per bit, window at 'h40.
module tb_uart_mmio_peripheral;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] word_addr = 32'h0;
   logic        write_en = 1'b0;
   logic        read_en = 1'b0;
   logic [31:0] write_data = 32'h0;
   logic [31:0] read_data;
   logic        hit;
   logic        uart_rx = 1'b1;
   logic        uart_tx;

   int vectors = 0;
   int miscompares = 0;

   logic [9:0] frame_a5;

   uart_mmio_peripheral #(
      .LENGTH(32), .BASE_WORD(32'h40), .CLKS_PER_BIT(4)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .word_addr(word_addr),
      .write_en(write_en), .read_en(read_en), .write_data(write_data),
      .read_data(read_data), .hit(hit), .uart_rx(uart_rx), .uart_tx(uart_tx)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic peek(input logic [31:0] a);
      enable = 1'b0;
      word_addr = a;
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      word_addr = a; write_data = d; enable = 1'b1; write_en = 1'b1;
      @(negedge clock);
      enable = 1'b0; write_en = 1'b0;
   endtask

   task automatic rx_read(input string tag, input logic [31:0] exp);
      word_addr = 32'h41; enable = 1'b1; read_en = 1'b1;
      #1;
      chk(tag, read_data, exp);
      @(negedge clock);
      enable = 1'b0; read_en = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      for (int i = 0; i < 10; i++) begin
         if (i == 0) uart_rx = 1'b0;
         else if (i == 9) uart_rx = stop;
         else uart_rx = d[i-1];
         repeat (4) @(negedge clock);
      end
      uart_rx = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_a5 = {1'b1, 8'hA5, 1'b0};

      // 1: reset and idle
      idle(2);
      reset = 1'b0;
      idle(20);
      #1;
      chk("idle_tx", 32'(uart_tx), 32'h1);
      peek(32'h42); chk("reset_status", read_data, 32'h0);
      peek(32'h43); chk("reset_ctrl", read_data, 32'h0);
      peek(32'h3F); chk("below_rd", read_data, 32'h0); chk("below_hit", 32'(hit), 32'h0);
      peek(32'h44); chk("above_rd", read_data, 32'h0); chk("above_hit", 32'(hit), 32'h0);
      peek(32'h40); chk("base_hit", 32'(hit), 32'h1);
      @(negedge clock);

      // 2: transmit A5, bit pattern and busy window
      bus_write(32'h40, 32'hA5);
      word_addr = 32'h42;
      for (int k = 0; k < 40; k++) begin
         #1;
         chk("tx_bit", 32'(uart_tx), 32'(frame_a5[k/4]));
         chk("tx_busy", 32'(read_data[0]), 32'h1);
         @(negedge clock);
      end
      #1;
      chk("tx_done_line", 32'(uart_tx), 32'h1);
      chk("tx_done_busy", read_data, 32'h0);
      @(negedge clock);

      // 3: write during busy is ignored and flags overflow
      bus_write(32'h40, 32'hA5);
      for (int k = 0; k < 40; k++) begin
         if (k == 12) begin
            word_addr = 32'h40; write_data = 32'h3C; enable = 1'b1; write_en = 1'b1;
         end else begin
            enable = 1'b0; write_en = 1'b0; word_addr = 32'h42;
         end
         #1;
         chk("ovf_tx_bit", 32'(uart_tx), 32'(frame_a5[k/4]));
         if (k == 13) chk("ovf_status", read_data, 32'h9);
         @(negedge clock);
      end
      peek(32'h42); chk("ovf_held", read_data, 32'h8);
      @(negedge clock);
      bus_write(32'h42, 32'h8);
      peek(32'h42); chk("ovf_cleared", read_data, 32'h0);
      @(negedge clock);

      // short low glitch must not start a frame
      uart_rx = 1'b0;
      @(negedge clock);
      uart_rx = 1'b1;
      idle(12);
      peek(32'h42); chk("glitch_status", read_data, 32'h0);
      @(negedge clock);

      // 4: receive 5A
      send_rx(8'h5A, 1'b1);
      idle(6);
      peek(32'h42); chk("rx_status", read_data, 32'h2);
      rx_read("rx_data_5a", 32'h5A);
      peek(32'h42); chk("rx_valid_clr", read_data, 32'h0);
      @(negedge clock);

      // 5: overrun, then bad stop bit
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      idle(6);
      peek(32'h42); chk("overrun_status", read_data, 32'h6);
      peek(32'h41); chk("overrun_keep", read_data, 32'h11);
      @(negedge clock);
      send_rx(8'h33, 1'b0);
      idle(6);
      peek(32'h42); chk("ferr_status", read_data, 32'h16);
      peek(32'h41); chk("ferr_keep", read_data, 32'h11);
      @(negedge clock);
      bus_write(32'h42, 32'h1C);
      rx_read("drain_11", 32'h11);
      peek(32'h42); chk("all_clear", read_data, 32'h0);
      @(negedge clock);

      // 6: loopback, then reset mid-frame
      bus_write(32'h43, 32'h1);
      peek(32'h43); chk("ctrl_set", read_data, 32'h1);
      @(negedge clock);
      bus_write(32'h40, 32'hC3);
      idle(46);
      peek(32'h42); chk("loop_status", read_data, 32'h2);
      peek(32'h41); chk("loop_data", read_data, 32'hC3);
      @(negedge clock);
      bus_write(32'h40, 32'h55);
      idle(9);
      #1;
      chk("pre_reset_tx", 32'(uart_tx), 32'h0);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("reset_tx", 32'(uart_tx), 32'h1);
      peek(32'h42); chk("reset2_status", read_data, 32'h0);
      peek(32'h43); chk("reset2_ctrl", read_data, 32'h0);
      peek(32'h41); chk("reset2_rxbyte", read_data, 32'h0);
      reset = 1'b0;
      idle(10);
      #1;
      chk("post_reset_tx", 32'(uart_tx), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
